reg_file_dump: RTL and testbench

- Debug read-out engine for the processor register file.
- On a start pulse it walks every register address through a register-file read port and captures each byte.
- Each captured byte goes out on a valid/ready byte stream, followed by one XOR checksum beat.
- Sits beside the register file; observes only, never writes registers; feeds the debug/trace link.

---
 rtl/reg_file_dump.sv | 156 +++++++++++++++
 tb/tb_reg_file_dump.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_dump.sv
// reg_file_dump: debug read-out engine for a processor register file.
// On a start request it walks every register address through a read
// port, captures each byte and streams it out, followed by one XOR
// checksum beat. It only observes the register file and never writes it.
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst_n       synchronous active-low reset
//   start       dump request, sampled only while idle
//   rd_addr     address driven to the register-file read port
//   rd_data     combinational read data for rd_addr
//   dump_data   stream byte (register value or checksum)
//   dump_valid  dump_data is valid
//   dump_ready  sink accepts the beat at a rising edge when valid is high
//   dump_last   high only on the checksum beat
//   dump_is_sum high when dump_data is the checksum
//   busy        high in every state other than IDLE
//   done        one-cycle pulse after the checksum beat is accepted
//
// Handshake: a beat transfers at a rising edge where dump_valid and
// dump_ready are both high. Once raised, dump_valid stays high and
// dump_data stays stable until that transfer; dump_ready while
// dump_valid is low has no effect.
module reg_file_dump #(
   parameter int pw = 3,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic [pw:0]   rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic [DW-1:0] dump_data,
   output logic          dump_valid,
   input  logic          dump_ready,
   output logic          dump_last,
   output logic          dump_is_sum,
   output logic          busy,
   output logic          done
);

   // Highest register index: NREG-1 with NREG = 2**pw.
   localparam logic [pw:0] LAST_IDX = {1'b0, {pw{1'b1}}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      SEND  = 3'd2,
      SUM   = 3'd3,
      FIN   = 3'd4
   } state_t;

   // state is kept as a named signal so checkers can bind to it.
   state_t        state;
   state_t        state_nx;
   logic [pw:0]   idx;
   logic [DW-1:0] sum;
   logic [DW-1:0] hold;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Datapath registers: address index, running checksum, byte holding reg.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx  <= '0;
         sum  <= '0;
         hold <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  idx <= '0;
                  sum <= '0;
               end
            end
            FETCH: begin
               // The checksum folds in exactly the byte that will be sent,
               // so a register changing mid-dump stays consistent.
               hold <= rd_data;
               sum  <= sum ^ rd_data;
            end
            SEND: begin
               // idx stops at the last register and never wraps.
               if (dump_ready && (idx != LAST_IDX)) begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = FETCH;
         FETCH: state_nx = SEND;
         SEND: begin
            if (dump_ready) begin
               state_nx = (idx == LAST_IDX) ? SUM : FETCH;
            end
         end
         SUM:   if (dump_ready) state_nx = FIN;
         FIN:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Output logic, purely a function of state and the datapath registers.
   always_comb begin
      rd_addr     = '0;
      dump_data   = '0;
      dump_valid  = 1'b0;
      dump_last   = 1'b0;
      dump_is_sum = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
         end
         FETCH: begin
            rd_addr = idx;
            busy    = 1'b1;
         end
         SEND: begin
            rd_addr    = idx;
            dump_data  = hold;
            dump_valid = 1'b1;
            busy       = 1'b1;
         end
         SUM: begin
            dump_data   = sum;
            dump_valid  = 1'b1;
            dump_last   = 1'b1;
            dump_is_sum = 1'b1;
            busy        = 1'b1;
         end
         FIN: begin
            done = 1'b1;
            busy = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_reg_file_dump.sv
// Testbench for reg_file_dump: a register-file model drives rd_data,
// directed tests push expected beats into a queue and a negedge monitor
// compares every presented beat against the queue front.
module tb_reg_file_dump;

   localparam int W = 10;  // {is_sum, last, data}

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic [7:0] dump_data;
   logic       dump_valid;
   logic       dump_ready;
   logic       dump_last;
   logic       dump_is_sum;
   logic       busy;
   logic       done;

   logic [7:0] regs [0:7];
   logic [W-1:0] exp_q[$];
   int checks;
   int errors;

   reg_file_dump #(.pw(3), .DW(8)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .dump_data(dump_data),
      .dump_valid(dump_valid),
      .dump_ready(dump_ready),
      .dump_last(dump_last),
      .dump_is_sum(dump_is_sum),
      .busy(busy),
      .done(done)
   );

   assign rd_data = regs[rd_addr[2:0]];

   // Clock / reset block.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Driver tasks. Inputs change 2 time units after the rising edge; outputs
   // read there reflect the state entered at that edge.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push_beats(input logic [7:0] b5, input logic [7:0] cs);
      logic [7:0] vals [0:7];
      vals = '{8'h00, 8'h01, 8'hA5, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      vals[5] = b5;
      for (int i = 0; i < 8; i++) exp_q.push_back({2'b00, vals[i]});
      exp_q.push_back({2'b11, cs});
   endtask

   task automatic push_std();
      push_beats(8'h05, 8'hA7);
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 200; i++) begin
         if (done) return;
         step();
      end
      chk({name, "_done_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_beat(input string name, input logic [7:0] b);
      for (int i = 0; i < 200; i++) begin
         if (dump_valid && !dump_is_sum && dump_data == b) return;
         step();
      end
      chk({name, "_beat_timeout"}, 32'd0, 32'd1);
   endtask

   // Monitor / scoreboard: compares the presented beat to the queue front,
   // pops on transfer.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && dump_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", {22'd0, dump_is_sum, dump_last, dump_data}, 32'hFFFF_FFFF);
            end else begin
               chk("beat", {22'd0, dump_is_sum, dump_last, dump_data}, {22'd0, exp_q[0]});
               if (dump_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      checks     = 0;
      errors     = 0;
      regs       = '{8'h00, 8'h01, 8'hA5, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      rst_n      = 1'b0;
      start      = 1'b1;
      dump_ready = 1'b1;

      // Reset with start held high: everything stays quiet.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("reset_outs", {19'd0, dump_valid, dump_last, dump_is_sum, busy, done, rd_addr, dump_data}, 32'd0);
      end
      push_std();
      rst_n = 1'b1;  // start still high: honored at the next edge
      step();
      chk("start_after_reset_busy", {31'd0, busy}, 32'd1);
      chk("start_after_reset_addr", {28'd0, rd_addr}, 32'd0);
      start = 1'b0;
      wait_done("t1");
      step();

      // Timed full dump, sink always ready; start sampled at edge 0.
      push_std();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 19; c++) begin
         if (c == 1) begin
            chk("lat_fetch_addr", {28'd0, rd_addr}, 32'd0);
            chk("lat_fetch_state", {29'd0, busy, dump_valid, done}, 32'b100);
         end else if (c <= 16) begin
            chk($sformatf("lat_valid_c%0d", c), {31'd0, dump_valid}, (c % 2 == 0) ? 32'd1 : 32'd0);
         end else if (c == 17) begin
            chk("lat_sum_beat", {29'd0, dump_valid, dump_last, dump_is_sum}, 32'b111);
         end else if (c == 18) begin
            chk("lat_done", {29'd0, done, busy, dump_valid}, 32'b110);
         end else begin
            chk("lat_idle", {30'd0, busy, done}, 32'd0);
         end
         step();
      end

      // Backpressure on beat 2.
      push_std();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_beat("bp", 8'hA5);
      dump_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_hold_valid", {31'd0, dump_valid}, 32'd1);
      end
      dump_ready = 1'b1;
      wait_done("bp");
      step();

      // start while busy (beat 4 and FIN) is ignored; start right after FIN launches.
      push_std();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_beat("busy_start", 8'h04);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done("busy_start");
      chk("one_dump_all_beats", exp_q.size(), 32'd0);
      push_std();
      start = 1'b1;  // sampled at the FIN edge: ignored
      step();
      chk("fin_start_ignored", {31'd0, busy}, 32'd0);
      step();        // sampled in IDLE: launches the second dump
      chk("second_dump_busy", {31'd0, busy}, 32'd1);
      start = 1'b0;
      wait_done("second");
      step();

      // Reset during SEND of beat 3 aborts with no checksum.
      push_std();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_beat("mid_rst", 8'h03);
      rst_n      = 1'b0;
      dump_ready = 1'b0;
      step();
      chk("mid_rst_outs", {30'd0, dump_valid, busy}, 32'd0);
      exp_q.delete();  // aborted beats must never appear
      rst_n      = 1'b1;
      dump_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("mid_rst_quiet", {30'd0, dump_valid, busy}, 32'd0);
      push_std();
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done("after_rst");
      step();

      // Live update: register 5 changes to FF before its fetch.
      push_beats(8'hFF, 8'h5D);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_beat("live", 8'h04);
      regs[5] = 8'hFF;
      wait_done("live");
      step();
      regs[5] = 8'h05;

      step();
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
